// File: rtl/mdu_hilo_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } mdu_state_t;

  localparam int unsigned DIV_STEPS = 32;

endpackage

// File: rtl/mdu_hilo_if.sv
// Execute-stage bus between the decode/control side and the HI/LO unit.
interface mdu_hilo_if;
  logic        start;
  logic [1:0]  alu_md;
  logic [31:0] a;
  logic [31:0] b;
  logic        op_mthi;
  logic        op_mtlo;
  logic        op_mfhi;
  logic        op_mflo;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        div_zero;

  modport master (
    output start, alu_md, a, b, op_mthi, op_mtlo, op_mfhi, op_mflo, wdata,
    input  rdata, hi, lo, busy, stall, div_zero
  );

  modport slave (
    input  start, alu_md, a, b, op_mthi, op_mtlo, op_mfhi, op_mflo, wdata,
    output rdata, hi, lo, busy, stall, div_zero
  );
endinterface

// File: rtl/mdu_hilo_div_core.sv
// Iterative unsigned 32/32 restoring divider, one quotient bit per cycle.
// done is high in the cycle the final step is taken; quot/rem are valid after it.
module div_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        done
);

  logic [31:0] dsr;
  logic [5:0]  cnt;
  logic [32:0] sh;
  logic        ge;
  logic [31:0] diff;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    sh   = {rem, quot[31]};
    ge   = (sh >= {1'b0, dsr});
    diff = sh[31:0] - dsr;
  end

  assign done = (cnt == 6'd1);

  // Quotient shifts in from the dividend register as bits are produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot <= '0;
      rem  <= '0;
      dsr  <= '0;
      cnt  <= '0;
    end else if (load) begin
      quot <= dividend;
      rem  <= '0;
      dsr  <= divisor;
      cnt  <= 6'(DIV_STEPS);
    end else if (cnt != '0) begin
      rem  <= ge ? diff : sh[31:0];
      quot <= {quot[30:0], ge};
      cnt  <= cnt - 6'd1;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers and pipeline stall.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = 3
) (
  input logic        clk,
  input logic        rst,
  mdu_hilo_if.slave  bus
);

  mdu_state_t  state, state_nxt;
  md_op_t      op_q;
  logic [2:0]  cnt;
  logic [31:0] a_q, b_q;
  logic        neg_q, neg_r, b_zero;
  logic [31:0] hi_r, lo_r;
  logic        accept, mul_wr, fix_wr;
  logic [63:0] prod;
  logic [31:0] abs_a, abs_b, quot_s, rem_s;
  logic [31:0] dc_quot, dc_rem;
  logic        dc_done, dc_load;
  logic        is_div_in, is_sdiv_in;

  assign is_div_in  = bus.alu_md[1];
  assign is_sdiv_in = (md_op_t'(bus.alu_md) == MD_DIV);
  assign dc_load    = accept & is_div_in;

  // Magnitudes for the divider; only signed divide takes absolute values.
  always_comb begin
    abs_a = (is_sdiv_in && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    abs_b = (is_sdiv_in && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
  end

  div_core u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (dc_load),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quot     (dc_quot),
    .rem      (dc_rem),
    .done     (dc_done)
  );

  // Product of the latched operands; sign extension gives the signed form.
  always_comb begin
    if (op_q == MD_MULT)
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else
      prod = {32'd0, a_q} * {32'd0, b_q};
  end

  // Sign restoration of the unsigned divider result.
  always_comb begin
    quot_s = neg_q ? (32'd0 - dc_quot) : dc_quot;
    rem_s  = neg_r ? (32'd0 - dc_rem)  : dc_rem;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mul_wr    = 1'b0;
    fix_wr    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = is_div_in ? DIV : MUL;
      end
      MUL: if (cnt == '0) begin
        mul_wr    = 1'b1;
        state_nxt = IDLE;
      end
      DIV: if (dc_done) state_nxt = FIX;
      FIX: begin
        fix_wr    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, multiply countdown and HI/LO writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= MD_MULT;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      if (accept) begin
        op_q   <= md_op_t'(bus.alu_md);
        cnt    <= 3'(MULT_LAT - 1);
        a_q    <= bus.a;
        b_q    <= bus.b;
        neg_q  <= is_sdiv_in & (bus.a[31] ^ bus.b[31]);
        neg_r  <= is_sdiv_in & bus.a[31];
        b_zero <= (bus.b == '0);
      end else if (cnt != '0) begin
        cnt <= cnt - 3'd1;
      end

      if (mul_wr) begin
        hi_r <= prod[63:32];
        lo_r <= prod[31:0];
      end else if (fix_wr) begin
        hi_r <= b_zero ? a_q : rem_s;
        lo_r <= b_zero ? '1  : quot_s;
      end else if (state == IDLE && !bus.start) begin
        // A start in the same cycle takes priority and drops the move.
        if (bus.op_mthi) hi_r <= bus.wdata;
        if (bus.op_mtlo) lo_r <= bus.wdata;
      end
    end
  end

  // Read mux and status outputs.
  always_comb begin
    bus.rdata = '0;
    if (bus.op_mfhi)      bus.rdata = hi_r;
    else if (bus.op_mflo) bus.rdata = lo_r;
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = (state != IDLE);
  assign bus.stall    = bus.busy & (bus.start | bus.op_mthi | bus.op_mtlo |
                                    bus.op_mfhi | bus.op_mflo);
  assign bus.div_zero = (state == FIX) & b_zero;

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;

  localparam int unsigned LAT = 3;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.alu_md  = 2'b00;
    bus.a       = '0;
    bus.b       = '0;
    bus.op_mthi = 1'b0;
    bus.op_mtlo = 1'b0;
    bus.op_mfhi = 1'b0;
    bus.op_mflo = 1'b0;
    bus.wdata   = '0;
  endtask

  // Issue one op, count busy cycles and div_zero pulses, then score HI/LO.
  task automatic run_op(input string name, input vec_t v);
    int   n;
    int   dz;
    exp_t e;
    bus.start  = 1'b1;
    bus.alu_md = v.op;
    bus.a      = v.a;
    bus.b      = v.b;
    sb.push_back('{hi: v.hi, lo: v.lo});
    tick();
    bus.start = 1'b0;
    n  = 0;
    dz = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (bus.div_zero) dz++;
      tick();
    end
    check({name, ".busy_cycles"}, 32'(n), v.op[1] ? 32'd33 : 32'(LAT));
    check({name, ".div_zero_pulses"}, 32'(dz), v.dz ? 32'd1 : 32'd0);
    e = sb.pop_front();
    check({name, ".hi"}, bus.hi, e.hi);
    check({name, ".lo"}, bus.lo, e.lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] hold;
    total = 0;
    bad   = 0;

    vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[10] = '{2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[11] = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[12] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("reset.hi", bus.hi, 32'd0);
    check("reset.lo", bus.lo, 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.stall", 32'(bus.stall), 32'd0);
    check("reset.div_zero", 32'(bus.div_zero), 32'd0);
    check("reset.rdata", bus.rdata, 32'd0);

    // Back-to-back: each op is issued in the first idle cycle after the last.
    for (int i = 0; i < 13; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // mfhi stalled across a whole divide, reads the new HI once released.
    bus.start  = 1'b1;
    bus.alu_md = 2'b10;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    tick();
    bus.start   = 1'b0;
    bus.op_mfhi = 1'b1;
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      tick();
    end
    check("mfhi.stall_cycles", 32'(n), 32'd33);
    check("mfhi.rdata", bus.rdata, 32'd2);
    bus.op_mfhi = 1'b0;
    bus.op_mflo = 1'b1;
    #1;
    check("mflo.rdata", bus.rdata, 32'd14);
    bus.op_mflo = 1'b0;
    #1;
    check("nosel.rdata", bus.rdata, 32'd0);

    // mthi while busy: no effect until the multiply completes, then writes.
    hold       = bus.hi;
    bus.start  = 1'b1;
    bus.alu_md = 2'b00;
    bus.a      = 32'd2;
    bus.b      = 32'd3;
    tick();
    bus.start   = 1'b0;
    bus.op_mthi = 1'b1;
    bus.wdata   = 32'hAAAA5555;
    tick();
    check("mthi.hi_held", bus.hi, hold);
    n = 1;
    while (bus.stall && n < 100) begin
      n++;
      tick();
    end
    check("mthi.stall_cycles", 32'(n), 32'(LAT));
    tick();
    bus.op_mthi = 1'b0;
    check("mthi.hi", bus.hi, 32'hAAAA5555);
    check("mthi.lo", bus.lo, 32'd6);

    // start with mtlo in idle: the multiply wins and the move is dropped.
    bus.start   = 1'b1;
    bus.alu_md  = 2'b01;
    bus.a       = 32'd5;
    bus.b       = 32'd9;
    bus.op_mtlo = 1'b1;
    bus.wdata   = 32'h00000055;
    tick();
    idle_inputs();
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    check("start_vs_mtlo.lo", bus.lo, 32'd45);
    check("start_vs_mtlo.hi", bus.hi, 32'd0);

    // Reset in the middle of a divide discards it.
    bus.start  = 1'b1;
    bus.alu_md = 2'b10;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("midrst.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.hi", bus.hi, 32'd0);
    check("midrst.lo", bus.lo, 32'd0);
    bus.op_mtlo = 1'b1;
    bus.wdata   = 32'd5;
    tick();
    bus.op_mtlo = 1'b0;
    check("midrst.mtlo", bus.lo, 32'd5);
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) check("midrst.stays_idle", 32'(bus.busy), 32'd0);
      tick();
    end
    check("midrst.lo_final", bus.lo, 32'd5);
    check("midrst.hi_final", bus.hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide unit with architectural HI/LO registers; the execute-stage consumer of the control unit's `md`, `alu_md` and `op_mthi/op_mtlo/op_mfhi/op_mflo` decode outputs. Accepts one mult/multu/div/divu per start, runs it over multiple cycles, and writes HI/LO on completion. Raises `stall` to freeze the pipeline when a later HI/LO access or a new start arrives while busy.

## Interface
- `MULT_LAT`, default 3: cycles from accept to HI/LO write for multiplies; legal range 1..8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high.
- `start` in 1: the control unit's `md`; request to begin an operation.
- `alu_md` in 2: 00 mult, 01 multu, 10 div, 11 divu.
- `a` in 32: rs operand (multiplicand or dividend).
- `b` in 32: rt operand (multiplier or divisor).
- `op_mthi`, `op_mtlo` in 1 each: write `wdata` to HI or LO.
- `op_mfhi`, `op_mflo` in 1 each: select HI or LO onto `rdata`.
- `wdata` in 32: rs value for mthi/mtlo.
- `rdata` out 32: combinational; HI if `op_mfhi`, LO if `op_mflo`, else 0.
- `hi`, `lo` out 32 each: current register contents.
- `busy` out 1: operation in flight.
- `stall` out 1: `busy & (start | op_mthi | op_mtlo | op_mfhi | op_mflo)`.
- `div_zero` out 1: one-cycle pulse, asserted in the cycle the zero-divisor result is written.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, `start`=1: latch op, `a` and `b`, load the counter, set `busy`. Multiplies go to MUL. Divides go to DIV.
  - For signed div, latch |a| and |b| and record sign(a) and sign(a)^sign(b).
- MUL: counter runs MULT_LAT cycles. On the last cycle, write {HI,LO} = 64-bit product (signed for mult, unsigned for multu), then IDLE.
- DIV: restoring radix-2, one quotient bit per cycle, 32 cycles, then FIX.
- FIX: apply signs, write HI = remainder and LO = quotient, then IDLE.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (div): LO = 0x80000000, HI = 0.
- Divisor zero, both div and divu: normal latency. In FIX, HI = `a` as latched, LO = 0xFFFFFFFF, `div_zero` pulses.
- mthi/mtlo in IDLE, or in the same cycle `busy` falls: write on that edge.
- `start` together with mthi/mtlo in IDLE: start wins; the move is dropped. The decoder never issues both.
- `start` or any HI/LO access while `busy`: `stall`=1 and no effect. The upstream holds the instruction until `busy` clears.
- `rst` in any state: IDLE, HI = LO = 0, `busy` = 0, `div_zero` = 0. An in-flight operation is discarded with no partial HI/LO write.

## Timing
- Reset values: `hi`, `lo`, `busy`, `stall`, `div_zero` all 0. `rdata` is 0 unless a select is high.
- Accept at cycle T for a multiply:
  - `busy` is high in cycles T+1..T+MULT_LAT.
  - The new HI/LO is visible in cycle T+MULT_LAT+1, when `busy` is 0.
- Accept at cycle T for a divide:
  - DIV runs cycles T+1..T+32; FIX is cycle T+33.
  - `busy` is high in cycles T+1..T+33.
  - The result is visible in cycle T+34.
- `busy` falls combinationally with the write edge, so an mfhi stalled in the final busy cycle reads the new value in the next cycle.
- Back-to-back: a new `start` is accepted in the first cycle `busy` is 0.

## Structure
- Package `mdu_pkg`:
  - `alu_md` encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - State enum: IDLE, MUL, DIV, FIX.
  - Constant DIV_STEPS = 32.
- Sub-module `div_core`: iterative unsigned 32/32 restoring divider.
  - Ports: `clk`, `rst`, `load`, `dividend`, `divisor`, `quot`, `rem`, `done`.
  - `mdu_hilo` owns sign handling, HI/LO and the FSM.

## Test plan
- Reset, then mult a=0xFFFFFFFE (-2), b=3 with MULT_LAT=3 -> `busy` high 3 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div a=-7 (0xFFFFFFF9), b=2 -> after 33 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu 7/2 -> LO=3, HI=1.
- divu a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234, `div_zero` pulses for exactly one cycle. div 0x80000000 / -1 -> LO=0x80000000, HI=0.
- mfhi issued the cycle after a div accept -> `stall` high 33 cycles; `rdata` equals the new HI in the first cycle `stall` is low. mthi 0xAAAA5555 while busy -> stalls, then writes after completion.
- Assert `rst` at cycle 10 of a div -> next cycle `busy`=0, HI=LO=0; a following mtlo 5 gives LO=5.
